// File: rtl/rr_mux_pkg.sv
// rtl/rr_mux_pkg.sv - shared types and constants for the round-robin stream mux
// Grant states, source encodings and the beat-counter width helper.
package rr_mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } grant_state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // A single-beat burst limit still needs a one-bit counter to stay legal.
    function automatic int unsigned cnt_width(input int unsigned max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// rtl/stream_out_reg.sv - single-stage valid/ready output register
// A push on in_valid_i is taken only while load_o is high; load_o is the upstream ready.
module stream_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_last_i,
    output logic             load_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_last_o,
    input  logic             out_ready_i
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;

    assign load_o      = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (in_valid_i && load_o) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
            last_d  = in_last_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// rtl/rr_stream_mux.sv - two-source burst round-robin stream mux with registered output
// A source owns the output until it sends last or reaches MAX_BURST beats.
module rr_stream_mux
    import rr_mux_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             a_valid_i,
    input  logic [WIDTH-1:0] a_data_i,
    input  logic             a_last_i,
    output logic             a_ready_o,
    input  logic             b_valid_i,
    input  logic [WIDTH-1:0] b_data_i,
    input  logic             b_last_i,
    output logic             b_ready_o,
    output logic             sel_o,
    output logic             y_valid_o,
    output logic [WIDTH-1:0] y_data_o,
    output logic             y_last_o,
    input  logic             y_ready_i
);

    localparam int CW = int'(cnt_width(MAX_BURST));
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    grant_state_t    state_q, state_d;
    logic            ptr_q, ptr_d;
    logic            sel_q;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            grant;
    logic            grant_any;
    logic            load;
    logic            xfer;
    logic            src_last;
    logic [WIDTH-1:0] src_data;

    // In IDLE with nobody requesting, the previous grant is held on sel_o.
    always_comb begin
        grant     = sel_q;
        grant_any = 1'b0;
        case (state_q)
            LOCK_A: begin
                grant     = SRC_A;
                grant_any = 1'b1;
            end
            LOCK_B: begin
                grant     = SRC_B;
                grant_any = 1'b1;
            end
            default: begin
                if (a_valid_i && b_valid_i) begin
                    grant = ptr_q;
                end else if (a_valid_i) begin
                    grant = SRC_A;
                end else if (b_valid_i) begin
                    grant = SRC_B;
                end
                grant_any = a_valid_i || b_valid_i;
            end
        endcase
    end

    assign sel_o     = grant;
    assign a_ready_o = !reset_i && grant_any && (grant == SRC_A) && load;
    assign b_ready_o = !reset_i && grant_any && (grant == SRC_B) && load;
    assign xfer      = (a_valid_i && a_ready_o) || (b_valid_i && b_ready_o);
    assign src_data  = (grant == SRC_B) ? b_data_i : a_data_i;
    assign src_last  = (grant == SRC_B) ? b_last_i : a_last_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            if (src_last || (cnt_q == CNT_LAST)) begin
                state_d = IDLE;
                cnt_d   = '0;
                ptr_d   = ~grant;
            end else begin
                state_d = (grant == SRC_B) ? LOCK_B : LOCK_A;
                cnt_d   = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= SRC_A;
            sel_q   <= SRC_A;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sel_q   <= grant;
        end
    end

    stream_out_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .in_valid_i (xfer),
        .in_data_i  (src_data),
        .in_last_i  (src_last),
        .load_o     (load),
        .out_valid_o(y_valid_o),
        .out_data_o (y_data_o),
        .out_last_o (y_last_o),
        .out_ready_i(y_ready_i)
    );

endmodule
